// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkt_reader
//  Purpose  : Read-side controller for a synchronous show-ahead FIFO. Pops
//             words, frames them into PKT_LEN-word packets and presents them
//             on a registered valid/ready stream with m_last.
//  Options  : FIFO_PKT_READER_PAD_EN - when defined, a packet that stalls on
//             an empty FIFO for TIMEOUT cycles is completed with zero words
//             flagged by pad_flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_pkt_reader #(
   parameter int DATA_W  = 128,
   parameter int PKT_LEN = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_rd_data,
   input  logic              fifo_empty,
   input  logic              fifo_almst_empty,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              pad_flag,
   output logic [15:0]       pkt_count
);

   localparam int               BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef FIFO_PKT_READER_PAD_EN
   localparam logic [1:0] ST_PAD    = 2'd2;
   localparam int         STALL_W   = $clog2(TIMEOUT + 1);
`endif

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [BEAT_W-1:0] beat_cnt;
   logic              out_free;
   logic              start;
   logic              pop;
   logic              pad_load;
   logic              load;
   logic              last_load;

`ifdef FIFO_PKT_READER_PAD_EN
   logic [STALL_W-1:0] stall_cnt;
   logic               timeout_hit;
   logic               pad_q;

   assign timeout_hit = (stall_cnt == STALL_W'(TIMEOUT));
   assign pad_flag    = pad_q;
`else
   assign pad_flag    = 1'b0;
`endif

   // State register; reset abandons any packet in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a packet ends when its last beat is loaded into the output slot
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (pop) begin
               if (last_load) begin
                  state_nxt = ST_IDLE;
               end
`ifdef FIFO_PKT_READER_PAD_EN
            end else if (timeout_hit) begin
               state_nxt = ST_PAD;
`endif
            end
         end
`ifdef FIFO_PKT_READER_PAD_EN
         ST_PAD: begin
            if (pad_load && last_load) begin
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs and strobes: pop is combinational so the start cycle already pops
   always_comb begin
      out_free = !m_valid || m_ready;
      start    = (state == ST_IDLE) && en && !fifo_almst_empty;
      pop      = reset && !fifo_empty && out_free && ((state == ST_ACTIVE) || start);
      pad_load = 1'b0;
`ifdef FIFO_PKT_READER_PAD_EN
      pad_load = reset && (state == ST_PAD) && out_free;
`endif
      load       = pop || pad_load;
      last_load  = load && (beat_cnt == LAST_BEAT);
      fifo_rd_en = pop;
      busy       = (state != ST_IDLE);
   end

   // Output slot, beat counter and completed-packet counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         beat_cnt  <= '0;
         pkt_count <= 16'd0;
      end else begin
         if (load) begin
            m_data   <= pad_load ? '0 : fifo_rd_data;
            m_valid  <= 1'b1;
            m_last   <= last_load;
            beat_cnt <= last_load ? '0 : beat_cnt + BEAT_W'(1);
         end else if (out_free) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if (m_valid && m_ready && m_last) begin
            pkt_count <= pkt_count + 16'd1;
         end
      end
   end

`ifdef FIFO_PKT_READER_PAD_EN
   // Pad marker follows the word it describes and holds through back-pressure
   always_ff @(posedge clk) begin
      if (!reset) begin
         pad_q <= 1'b0;
      end else if (load) begin
         pad_q <= pad_load;
      end else if (out_free) begin
         pad_q <= 1'b0;
      end
   end

   // Consecutive starved cycles while ACTIVE; any pop or leaving ACTIVE clears it
   always_ff @(posedge clk) begin
      if (!reset || (state != ST_ACTIVE) || pop) begin
         stall_cnt <= '0;
      end else if (fifo_empty && out_free && !timeout_hit) begin
         stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side controller for the team's synchronous show-ahead FIFO. It drains words through the FIFO's `rd_en`/`rd_data`/`empty`/`almst_empty` port, frames them into fixed-length packets of PKT_LEN words, and presents them on a registered valid/ready stream with `m_last`. It sits between the FIFO and a downstream packet consumer, and replaces ad-hoc pop logic at every FIFO output.

## Interface
- DATA_W, 128: word width; equals the FIFO's DATA_W.
- PKT_LEN, 8: words per packet; must be ≥ 2.
- TIMEOUT, 16: idle-stall cycles before padding; must be ≥ 1; used only with the macro.

- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  allows a new packet to start; sampled only in IDLE.
- fifo_rd_en  out  1  FIFO pop strobe.
- fifo_rd_data  in  DATA_W  FIFO head word (show-ahead: valid while !fifo_empty).
- fifo_empty  in  1  FIFO empty.
- fifo_almst_empty  in  1  FIFO count < LOW_TH.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_W  output word.
- m_last  out  1  final word of packet.
- busy  out  1  packet in progress (state != IDLE).
- pad_flag  out  1  current output word is padding.
- pkt_count  out  16  completed packets; wraps at 0xFFFF→0.

## Operation
- States: IDLE, ACTIVE, PAD (PAD reachable only with the macro).
- IDLE→ACTIVE: when `en && !fifo_almst_empty`. The FIFO holds ≥ LOW_TH words, so a packet does not start on a trickle.
- Output slot free: `out_free = !m_valid || m_ready`.
- `fifo_rd_en = reset && !fifo_empty && out_free && (state==ACTIVE || IDLE→ACTIVE transition this cycle)`. It is combinational, so the first pop happens in the transition cycle.
- On a pop: `m_data <= fifo_rd_data`, `m_valid <= 1`, `m_last <= (beat_cnt == PKT_LEN-1)`, `beat_cnt++`.
- When there is no pop and the slot is free: `m_valid <= 0`, `m_last <= 0`.
- `beat_cnt` is $clog2(PKT_LEN) bits wide and is cleared when the last beat is loaded.
- Loading the last beat returns the block to IDLE. `pkt_count` increments on the handshake (`m_valid && m_ready && m_last`).
- `en` falling mid-packet: the current packet completes. Only new starts are blocked.
- FIFO empty mid-packet: stay in ACTIVE. `m_valid` drops once the held word is taken. No data loss and no `m_last`.
- Empty and almost-empty flags are trusted as given; the block never pops while `fifo_empty` is 1.

## Timing
- Pop at edge N: the word is on `m_data` with `m_valid=1` from cycle N+1. Read latency is 1 cycle.
- Sustained throughput is 1 word/cycle while `m_ready=1` and the FIFO is non-empty. There are no bubbles between packets if the IDLE start condition holds.
- When `m_valid && !m_ready`: `m_data`, `m_last` and `pad_flag` hold stable and `fifo_rd_en=0`.
- Reset (any cycle, including mid-packet) takes effect at the next edge:
  - state = IDLE, `beat_cnt` = 0, stall counter = 0.
  - `m_valid`, `m_last`, `pad_flag`, `busy` = 0; `m_data` = 0; `pkt_count` = 0.
  - `fifo_rd_en` = 0 while reset is low.
  - A partial packet is abandoned with no `m_last`.

## Configuration
- Macro `FIFO_PKT_READER_PAD_EN`.
- Defined:
  - A stall counter counts consecutive ACTIVE cycles with `fifo_empty && out_free`. Any pop clears it.
  - When the counter reaches TIMEOUT, ACTIVE→PAD.
  - PAD loads zero words (`pad_flag=1`) whenever `out_free`, counting beats normally. The final pad word carries `m_last=1`; then PAD→IDLE.
  - PAD ignores the FIFO (`fifo_rd_en=0`).
- Undefined:
  - The PAD state and stall counter are not built.
  - `pad_flag` is tied to 0.
  - ACTIVE waits indefinitely for data.

## Test plan
- Preload FIFO with 8 words 0x1..0x8, hold en=1 and m_ready=1:
  - 8 consecutive m_valid cycles, data 0x1..0x8.
  - m_last only on 0x8; pkt_count=1.
- Preload 16 words, m_ready toggling 1/0 each cycle:
  - m_data stable through stalls; no word lost or duplicated.
  - Two packets, pkt_count=2.
- FIFO count=1 (almst_empty=1, LOW_TH=2), en=1:
  - No pop and busy=0 until a second word is written; then the packet starts.
- Macro off: 5 words then FIFO empty for 100 cycles:
  - busy=1 and m_last never asserted.
  - 3 more words complete the packet with m_last on word 8.
- Macro on, TIMEOUT=16: 5 words then FIFO empty:
  - After 16 stall cycles, 3 zero words with pad_flag=1.
  - m_last on the 3rd zero word; state back to IDLE.
- Reset low mid-packet after 4 beats:
  - Next cycle m_valid=0, busy=0, pkt_count=0.
  - Post-reset, the next packet's first word is beat 0.
